// File: rtl/issue_queue_age.sv
// ---------------------------------------------------------------------------
// issue_queue_age
// Out-of-order issue queue sitting between rename and the functional units.
// Each entry holds one renamed op and its two source operands. Operands that
// are still pending are captured from the CDB result buses. Every cycle the
// oldest entry that is ready to go is issued, as chosen by an age matrix.
// An entry is ready when both sources are valid, its store-buffer wait has
// cleared and its target FU can accept an op.
//
// Optional feature (macro ISSUE_Q_ENQ_WAKEUP_EN):
//   When defined, the sources of an op being enqueued are also compared
//   against the CDB of the same cycle and are captured valid on a match.
//   When undefined, rename is expected to cover that case with RF bypass.
// ---------------------------------------------------------------------------
module issue_queue_age #(
    parameter int DEPTH     = 8,
    parameter int NUM_FU    = 4,
    parameter int NUM_CDB   = 4,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 16,
    parameter int PAYLOAD_W = 48,
    parameter int SB_ENTRY  = 8,
    // Derived widths; not meant to be overridden
    parameter int FU_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    parameter int SB_W      = (SB_ENTRY > 1) ? $clog2(SB_ENTRY) : 1,
    parameter int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    // enqueue from rename
    input  logic                         enq_v_i,
    output logic                         enq_ready_o,
    input  logic [PAYLOAD_W-1:0]         enq_payload_i,
    input  logic [FU_W-1:0]              enq_fu_i,
    input  logic [TAG_W-1:0]             enq_src1_tag_i,
    input  logic                         enq_src1_v_i,
    input  logic [DATA_W-1:0]            enq_src1_data_i,
    input  logic [TAG_W-1:0]             enq_src2_tag_i,
    input  logic                         enq_src2_v_i,
    input  logic [DATA_W-1:0]            enq_src2_data_i,
    input  logic                         enq_sb_wait_i,
    input  logic [SB_W-1:0]              enq_sb_idx_i,
    // store buffer release pulses
    input  logic [SB_ENTRY-1:0]          sb_release_i,
    // result broadcast buses
    input  logic [NUM_CDB-1:0]           cdb_v_i,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag_i,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_data_i,
    // functional unit handshake
    input  logic [NUM_FU-1:0]            fu_ready_i,
    input  logic                         flush_i,
    output logic [NUM_FU-1:0]            iss_v_o,
    output logic [PAYLOAD_W-1:0]         iss_payload_o,
    output logic [DATA_W-1:0]            iss_src1_data_o,
    output logic [DATA_W-1:0]            iss_src2_data_o,
    output logic [CNT_W-1:0]             count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // -----------------------------------------------------------------------
    // Entry state
    // -----------------------------------------------------------------------
    logic [DEPTH-1:0]                 valid_reg;
    // older_reg[j][i] = 1 means entry j was enqueued before entry i
    logic [DEPTH-1:0][DEPTH-1:0]      older_reg;
    logic [CNT_W-1:0]                 count_reg;

    logic [DEPTH-1:0][PAYLOAD_W-1:0]  payload_reg;
    logic [DEPTH-1:0][FU_W-1:0]       fu_reg;
    logic [DEPTH-1:0][TAG_W-1:0]      src1_tag_reg;
    logic [DEPTH-1:0][TAG_W-1:0]      src2_tag_reg;
    logic [DEPTH-1:0]                 src1_v_reg;
    logic [DEPTH-1:0]                 src2_v_reg;
    logic [DEPTH-1:0][DATA_W-1:0]     src1_data_reg;
    logic [DEPTH-1:0][DATA_W-1:0]     src2_data_reg;
    logic [DEPTH-1:0]                 sb_wait_reg;
    logic [DEPTH-1:0][SB_W-1:0]       sb_idx_reg;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [NUM_CDB-1:0][TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB-1:0][DATA_W-1:0]   cdb_data;
    logic [DEPTH-1:0][DEPTH-1:0]      older_col;   // older_col[i][j] = older_reg[j][i]
    logic [DEPTH-1:0]                 elig;
    logic [DEPTH-1:0]                 sel;
    logic [DEPTH-1:0]                 enq_onehot;
    logic [IDX_W-1:0]                 free_idx;
    logic                             issue_ok;
    logic                             enq_fire;
    logic                             iss_fire;
    logic                             enq_s1_v;
    logic                             enq_s2_v;
    logic [DATA_W-1:0]                enq_s1_data;
    logic [DATA_W-1:0]                enq_s2_data;
    logic [NUM_FU-1:0]                iss_v;
    logic [PAYLOAD_W-1:0]             iss_payload;
    logic [DATA_W-1:0]                iss_src1_data;
    logic [DATA_W-1:0]                iss_src2_data;

    genvar gi, gj;

    // Split the flat CDB buses into per-bus fields
    generate
        for (gi = 0; gi < NUM_CDB; gi++) begin : g_cdb
            assign cdb_tag[gi]  = cdb_tag_i[gi*TAG_W +: TAG_W];
            assign cdb_data[gi] = cdb_data_i[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Issue is suppressed while in reset and during a flush
    assign issue_ok = reset_n_i & ~flush_i;

    // Per-entry readiness and oldest-ready selection. An entry is selected
    // when it is ready and no other ready entry is older than it.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_sel
            for (gj = 0; gj < DEPTH; gj++) begin : g_col
                assign older_col[gi][gj] = older_reg[gj][gi];
            end
            assign elig[gi] = valid_reg[gi] & src1_v_reg[gi] & src2_v_reg[gi]
                            & ~sb_wait_reg[gi] & fu_ready_i[fu_reg[gi]];
            assign sel[gi]  = issue_ok & elig[gi] & ~(|(elig & older_col[gi]));
        end
    endgenerate

    assign iss_fire = |sel;

    // Credit is taken from registered occupancy only
    assign enq_ready_o = reset_n_i & (count_reg != FULL_CNT);
    assign enq_fire    = enq_v_i & enq_ready_o & ~flush_i;
    assign count_o     = count_reg;

    // Lowest-index free slot receives the next enqueue
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_idx = IDX_W'(i);
            end
        end
        enq_onehot = '0;
        if (enq_fire) begin
            enq_onehot[free_idx] = 1'b1;
        end
    end

    // Source operand state at insertion, optionally woken by the same-cycle CDB
    always_comb begin
        enq_s1_v    = enq_src1_v_i;
        enq_s1_data = enq_src1_data_i;
        enq_s2_v    = enq_src2_v_i;
        enq_s2_data = enq_src2_data_i;
`ifdef ISSUE_Q_ENQ_WAKEUP_EN
        // Scan from the highest bus down so the lowest matching bus wins
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (!enq_src1_v_i && cdb_v_i[k] && (cdb_tag[k] == enq_src1_tag_i)) begin
                enq_s1_v    = 1'b1;
                enq_s1_data = cdb_data[k];
            end
            if (!enq_src2_v_i && cdb_v_i[k] && (cdb_tag[k] == enq_src2_tag_i)) begin
                enq_s2_v    = 1'b1;
                enq_s2_data = cdb_data[k];
            end
        end
`endif
    end

    // Issue mux: selection is one-hot, so an AND-OR reduction is enough and
    // every output stays zero when nothing issues
    always_comb begin
        iss_v         = '0;
        iss_payload   = '0;
        iss_src1_data = '0;
        iss_src2_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                iss_v[fu_reg[i]] = 1'b1;
                iss_payload      = iss_payload   | payload_reg[i];
                iss_src1_data    = iss_src1_data | src1_data_reg[i];
                iss_src2_data    = iss_src2_data | src2_data_reg[i];
            end
        end
    end

    assign iss_v_o         = iss_v;
    assign iss_payload_o   = iss_payload;
    assign iss_src1_data_o = iss_src1_data;
    assign iss_src2_data_o = iss_src2_data;

    // Occupancy, entry valid bits and age matrix
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            valid_reg <= '0;
            count_reg <= '0;
            older_reg <= '0;
        end else if (flush_i) begin
            valid_reg <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= (valid_reg & ~sel) | enq_onehot;
            count_reg <= count_reg + CNT_W'(enq_fire) - CNT_W'(iss_fire);
            if (enq_fire) begin
                // The new entry is younger than every other slot; stale bits
                // left by earlier occupants of this slot are overwritten here
                older_reg[free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (IDX_W'(j) != free_idx) begin
                        older_reg[j][free_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Entry payload, operand capture from the CDB and store-buffer release
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            // Later assignments win, so scanning downward gives lowest bus priority
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (!src1_v_reg[i] && cdb_v_i[k] && (cdb_tag[k] == src1_tag_reg[i])) begin
                    src1_v_reg[i]    <= 1'b1;
                    src1_data_reg[i] <= cdb_data[k];
                end
                if (!src2_v_reg[i] && cdb_v_i[k] && (cdb_tag[k] == src2_tag_reg[i])) begin
                    src2_v_reg[i]    <= 1'b1;
                    src2_data_reg[i] <= cdb_data[k];
                end
            end
            if (sb_wait_reg[i] && sb_release_i[sb_idx_reg[i]]) begin
                sb_wait_reg[i] <= 1'b0;
            end
        end
        if (enq_fire) begin
            payload_reg[free_idx]   <= enq_payload_i;
            fu_reg[free_idx]        <= enq_fu_i;
            src1_tag_reg[free_idx]  <= enq_src1_tag_i;
            src2_tag_reg[free_idx]  <= enq_src2_tag_i;
            src1_v_reg[free_idx]    <= enq_s1_v;
            src2_v_reg[free_idx]    <= enq_s2_v;
            src1_data_reg[free_idx] <= enq_s1_data;
            src2_data_reg[free_idx] <= enq_s2_data;
            sb_wait_reg[free_idx]   <= enq_sb_wait_i;
            sb_idx_reg[free_idx]    <= enq_sb_idx_i;
        end
    end

endmodule

// File: tb/tb_issue_queue_age.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_age
// Directed scenarios followed by randomized traffic. A reference model keeps
// the queued ops in a plain queue ordered by age; the oldest ready op is the
// first ready element of that queue.
// ---------------------------------------------------------------------------
module tb_issue_queue_age;

    localparam int DEPTH     = 8;
    localparam int NUM_FU    = 4;
    localparam int NUM_CDB   = 4;
    localparam int TAG_W     = 6;
    localparam int DATA_W    = 16;
    localparam int PAYLOAD_W = 48;
    localparam int SB_ENTRY  = 8;

    logic                       clk;
    logic                       reset_n;
    logic                       enq_v;
    logic                       enq_ready;
    logic [PAYLOAD_W-1:0]       enq_payload;
    logic [1:0]                 enq_fu;
    logic [TAG_W-1:0]           enq_src1_tag;
    logic                       enq_src1_v;
    logic [DATA_W-1:0]          enq_src1_data;
    logic [TAG_W-1:0]           enq_src2_tag;
    logic                       enq_src2_v;
    logic [DATA_W-1:0]          enq_src2_data;
    logic                       enq_sb_wait;
    logic [2:0]                 enq_sb_idx;
    logic [SB_ENTRY-1:0]        sb_release;
    logic [NUM_CDB-1:0]         cdb_v;
    logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]  cdb_data;
    logic [NUM_FU-1:0]          fu_ready;
    logic                       flush;
    logic [NUM_FU-1:0]          iss_v;
    logic [PAYLOAD_W-1:0]       iss_payload;
    logic [DATA_W-1:0]          iss_src1_data;
    logic [DATA_W-1:0]          iss_src2_data;
    logic [3:0]                 count;

    issue_queue_age dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .enq_v_i         (enq_v),
        .enq_ready_o     (enq_ready),
        .enq_payload_i   (enq_payload),
        .enq_fu_i        (enq_fu),
        .enq_src1_tag_i  (enq_src1_tag),
        .enq_src1_v_i    (enq_src1_v),
        .enq_src1_data_i (enq_src1_data),
        .enq_src2_tag_i  (enq_src2_tag),
        .enq_src2_v_i    (enq_src2_v),
        .enq_src2_data_i (enq_src2_data),
        .enq_sb_wait_i   (enq_sb_wait),
        .enq_sb_idx_i    (enq_sb_idx),
        .sb_release_i    (sb_release),
        .cdb_v_i         (cdb_v),
        .cdb_tag_i       (cdb_tag),
        .cdb_data_i      (cdb_data),
        .fu_ready_i      (fu_ready),
        .flush_i         (flush),
        .iss_v_o         (iss_v),
        .iss_payload_o   (iss_payload),
        .iss_src1_data_o (iss_src1_data),
        .iss_src2_data_o (iss_src2_data),
        .count_o         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: ops in enqueue order
    typedef struct {
        logic [PAYLOAD_W-1:0] payload;
        int                   fu;
        bit                   s1v;
        logic [TAG_W-1:0]     s1t;
        logic [DATA_W-1:0]    s1d;
        bit                   s2v;
        logic [TAG_W-1:0]     s2t;
        logic [DATA_W-1:0]    s2d;
        bit                   sbw;
        int                   sbi;
    } op_t;

    op_t q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Index of the oldest ready op, or -1 when nothing may issue
    function automatic int pick();
        if (!reset_n || flush) return -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].s1v && q[i].s2v && !q[i].sbw && fu_ready[q[i].fu]) return i;
        end
        return -1;
    endfunction

    // Capture a pending operand from the first CDB bus that carries its tag
    task automatic wake(input logic [TAG_W-1:0] tag, inout bit v, inout logic [DATA_W-1:0] d);
        if (!v) begin
            for (int k = 0; k < NUM_CDB; k++) begin
                if (cdb_v[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) begin
                    v = 1'b1;
                    d = cdb_data[k*DATA_W +: DATA_W];
                    break;
                end
            end
        end
    endtask

    // Compare the DUT outputs with the model for the inputs currently applied
    task automatic eval();
        int idx;
        logic [3:0] ev;
        logic [PAYLOAD_W-1:0] ep;
        logic [DATA_W-1:0] e1, e2;
        #1;
        idx = pick();
        ev = 4'd0; ep = '0; e1 = '0; e2 = '0;
        if (idx >= 0) begin
            ev = 4'(1 << q[idx].fu);
            ep = q[idx].payload;
            e1 = q[idx].s1d;
            e2 = q[idx].s2d;
        end
        check("iss_v", 64'(iss_v), 64'(ev));
        check("iss_payload", 64'(iss_payload), 64'(ep));
        check("iss_src1", 64'(iss_src1_data), 64'(e1));
        check("iss_src2", 64'(iss_src2_data), 64'(e2));
        check("count", 64'(count), 64'(q.size()));
        check("enq_ready", 64'(enq_ready), 64'(reset_n && (q.size() != DEPTH)));
    endtask

    // Advance the model across the coming clock edge, then wait for the negedge
    task automatic tick();
        int idx;
        bit fire;
        op_t e;
        idx = pick();
        if (!reset_n || flush) begin
            q.delete();
        end else begin
            fire = enq_v && (q.size() != DEPTH);
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                wake(e.s1t, e.s1v, e.s1d);
                wake(e.s2t, e.s2v, e.s2d);
                if (e.sbw && sb_release[e.sbi]) e.sbw = 1'b0;
                q[i] = e;
            end
            if (idx >= 0) q.delete(idx);
            if (fire) begin
                e.payload = enq_payload;
                e.fu  = int'(enq_fu);
                e.s1v = enq_src1_v; e.s1t = enq_src1_tag; e.s1d = enq_src1_data;
                e.s2v = enq_src2_v; e.s2t = enq_src2_tag; e.s2d = enq_src2_data;
                e.sbw = enq_sb_wait; e.sbi = int'(enq_sb_idx);
`ifdef ISSUE_Q_ENQ_WAKEUP_EN
                wake(e.s1t, e.s1v, e.s1d);
                wake(e.s2t, e.s2v, e.s2d);
`endif
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        reset_n = 1'b1; flush = 1'b0; enq_v = 1'b0;
        enq_payload = '0; enq_fu = '0;
        enq_src1_tag = '0; enq_src1_v = 1'b0; enq_src1_data = '0;
        enq_src2_tag = '0; enq_src2_v = 1'b0; enq_src2_data = '0;
        enq_sb_wait = 1'b0; enq_sb_idx = '0; sb_release = '0;
        cdb_v = '0; cdb_tag = '0; cdb_data = '0; fu_ready = '0;
    endtask

    task automatic set_enq(input logic [PAYLOAD_W-1:0] p, input logic [1:0] fu, input bit s1v,
                           input logic [TAG_W-1:0] s1t, input bit sbw, input logic [2:0] sbi);
        enq_v = 1'b1; enq_payload = p; enq_fu = fu;
        enq_src1_v = s1v; enq_src1_tag = s1t; enq_src1_data = p[15:0];
        enq_src2_v = 1'b1; enq_src2_tag = '0; enq_src2_data = p[31:16];
        enq_sb_wait = sbw; enq_sb_idx = sbi;
    endtask

    task automatic randomize_inputs();
        reset_n = ($urandom_range(0, 199) != 0);
        flush   = ($urandom_range(0, 63) == 0);
        enq_v   = ($urandom_range(0, 9) < 7);
        enq_payload = {16'($urandom), $urandom};
        enq_fu  = 2'($urandom_range(0, 3));
        enq_src1_v = ($urandom_range(0, 9) < 5);
        enq_src2_v = ($urandom_range(0, 9) < 5);
        enq_src1_tag = 6'($urandom_range(0, 7));
        enq_src2_tag = 6'($urandom_range(0, 7));
        enq_src1_data = 16'($urandom);
        enq_src2_data = 16'($urandom);
        enq_sb_wait = ($urandom_range(0, 3) == 0);
        enq_sb_idx  = 3'($urandom_range(0, 7));
        sb_release  = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
        cdb_v = 4'($urandom);
        for (int k = 0; k < NUM_CDB; k++) begin
            cdb_tag[k*TAG_W +: TAG_W]    = 6'($urandom_range(0, 7));
            cdb_data[k*DATA_W +: DATA_W] = 16'($urandom);
        end
        fu_ready = 4'($urandom);
    endtask

    // Hard stop in case the stimulus ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed scenarios, then random traffic
    initial begin
        idle();
        reset_n = 1'b0; enq_v = 1'b1; fu_ready = '1;
        repeat (2) @(negedge clk);

        // Reset held three cycles with traffic offered
        repeat (3) begin
            eval();
            check("rst_iss_v", 64'(iss_v), 64'd0);
            check("rst_ready", 64'(enq_ready), 64'd0);
            check("rst_count", 64'(count), 64'd0);
            tick();
        end
        idle();
        eval();
        check("rel_ready", 64'(enq_ready), 64'd1);
        tick();

        // Single ready op on FU 2
        idle(); fu_ready = 4'b0100;
        set_enq(48'hA0A0_1111_2222, 2'd2, 1'b1, 6'd0, 1'b0, 3'd0);
        eval(); tick();
        idle(); fu_ready = 4'b0100;
        eval();
        check("t2_iss_v", 64'(iss_v), 64'h4);
        check("t2_payload", 64'(iss_payload), 64'hA0A0_1111_2222);
        tick();
        idle(); eval(); tick();

        // Pending op B overtaken by ready op C, then woken from CDB bus 3
        idle(); fu_ready = 4'b0001;
        set_enq(48'hB0B0_3333_4444, 2'd0, 1'b0, 6'd5, 1'b0, 3'd0);
        eval(); tick();
        idle(); fu_ready = 4'b0001;
        set_enq(48'hC0C0_5555_6666, 2'd0, 1'b1, 6'd0, 1'b0, 3'd0);
        eval(); tick();
        idle(); fu_ready = 4'b0001;
        eval();
        check("t3_c_first", 64'(iss_payload), 64'hC0C0_5555_6666);
        tick();
        idle(); fu_ready = 4'b0001;
        cdb_v = 4'b1000; cdb_tag[23:18] = 6'd5; cdb_data[63:48] = 16'hBEEF;
        eval();
        check("t3_b_wait", 64'(iss_v), 64'd0);
        tick();
        idle(); fu_ready = 4'b0001;
        eval();
        check("t3_b_payload", 64'(iss_payload), 64'hB0B0_3333_4444);
        check("t3_b_src1", 64'(iss_src1_data), 64'hBEEF);
        tick();

        // Fill the queue while FU 1 is stalled, then drain in age order
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            set_enq(48'h4000_0000_0000 + 48'(i * 16'h0101), 2'd1, 1'b1, 6'd0, 1'b0, 3'd0);
            eval(); tick();
        end
        idle();
        eval();
        check("t4_full_ready", 64'(enq_ready), 64'd0);
        check("t4_full_count", 64'(count), 64'd8);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            idle(); fu_ready = 4'b0010;
            if (i == 0) set_enq(48'hDEAD_0000_0000, 2'd1, 1'b1, 6'd0, 1'b0, 3'd0);
            eval();
            check("t4_order", 64'(iss_payload), 64'h4000_0000_0000 + 64'(i * 16'h0101));
            tick();
        end
        idle(); eval(); tick();

        // Store-buffer wait on entry 3
        idle(); fu_ready = 4'b1000;
        set_enq(48'h5000_7777_8888, 2'd3, 1'b1, 6'd0, 1'b1, 3'd3);
        eval(); tick();
        idle(); fu_ready = 4'b1000;
        eval();
        check("t5_hold", 64'(iss_v), 64'd0);
        tick();
        idle(); fu_ready = 4'b1000; sb_release = 8'h08;
        eval();
        check("t5_rel_cycle", 64'(iss_v), 64'd0);
        tick();
        idle(); fu_ready = 4'b1000;
        eval();
        check("t5_go", 64'(iss_v), 64'h8);
        tick();

        // Flush with five ops queued and an enqueue offered
        for (int i = 0; i < 5; i++) begin
            idle();
            set_enq(48'h6000_0000_0000 + 48'(i), 2'(i % 4), 1'b1, 6'd0, 1'b0, 3'd0);
            eval(); tick();
        end
        idle(); fu_ready = '1; flush = 1'b1;
        set_enq(48'h6FFF_0000_0000, 2'd0, 1'b1, 6'd0, 1'b0, 3'd0);
        eval();
        check("t6_flush_iss", 64'(iss_v), 64'd0);
        check("t6_pre_count", 64'(count), 64'd5);
        tick();
        idle(); fu_ready = '1;
        eval();
        check("t6_count", 64'(count), 64'd0);
        check("t6_iss", 64'(iss_v), 64'd0);
        tick();

        // Random traffic against the model
        repeat (3000) begin
            randomize_inputs();
            eval();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
